// File: rtl/time_pkg.sv
// time_pkg: shared BCD types, helpers and time-field range constants
package time_pkg;
   typedef logic [3:0] bcd_t;
   localparam int HR24_MAX = 23;
   localparam int HR12_MIN = 1;
   localparam int HR12_MAX = 12;
   localparam int MS_MAX   = 59;
   function automatic logic bcd_valid(bcd_t d);
      return d <= 4'd9;
   endfunction
   function automatic int bcd2_to_int(bcd_t tens, bcd_t ones);
      return 10 * int'(tens) + int'(ones);
   endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit with up/down step wrapping at top, load and carry/borrow-out
module bcd_digit
   import time_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  bcd_t rst_val,
   input  logic load,
   input  bcd_t load_val,
   input  logic up,
   input  logic dn,
   input  bcd_t top,
   output bcd_t q,
   output logic co,
   output logic bo
);
   bcd_t q_d, q_q;
   // next digit: reset > load > up > down, stepping wraps between 0 and top
   always_comb begin
      q_d = reset ? rst_val :
            load  ? load_val :
            up    ? (q_q == top ? 4'd0 : q_q + 4'd1) :
            dn    ? (q_q == 4'd0 ? top : q_q - 4'd1) : q_q;
      co  = ~reset & ~load & up & (q_q == top);
      bo  = ~reset & ~load & ~up & dn & (q_q == 4'd0);
   end
   // digit register
   always_ff @(posedge clk) begin
      q_q <= q_d;
   end
   assign q = q_q;
endmodule

// File: rtl/bcd_field_cnt.sv
// bcd_field_cnt: two-digit BCD time field with range, up/down, validated load and carry/borrow
module bcd_field_cnt
   import time_pkg::*;
#(
   parameter int MAX_VAL = 23,
   parameter int MIN_VAL = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [3:0] q_tens,
   output logic [3:0] q_ones,
   output logic       wrap,
   output logic       borrow,
   output logic       at_max,
   output logic       load_err
);
   localparam bcd_t MAX_T = bcd_t'(MAX_VAL / 10);
   localparam bcd_t MAX_O = bcd_t'(MAX_VAL % 10);
   localparam bcd_t MIN_T = bcd_t'(MIN_VAL / 10);
   localparam bcd_t MIN_O = bcd_t'(MIN_VAL % 10);
   logic at_min, load_ok, up, dn, d_load, load_err_d, load_err_q;
   logic o_co, o_bo, t_co, t_bo, unused_tens;
   bcd_t d_tens, d_ones;
   // field terminal detection; a field-level wrap/borrow reloads both digits with the opposite limit
   always_comb begin
      at_max     = (q_tens == MAX_T) && (q_ones == MAX_O);
      at_min     = (q_tens == MIN_T) && (q_ones == MIN_O);
      load_ok    = bcd_valid(load_val[7:4]) && bcd_valid(load_val[3:0]) &&
                   bcd2_to_int(load_val[7:4], load_val[3:0]) >= MIN_VAL &&
                   bcd2_to_int(load_val[7:4], load_val[3:0]) <= MAX_VAL;
      up         = ~reset & ~load & inc & ~dec;
      dn         = ~reset & ~load & dec & ~inc;
      wrap       = up & at_max;
      borrow     = dn & at_min;
      d_load     = (load & load_ok) | wrap | borrow;
      d_tens     = wrap ? MIN_T : borrow ? MAX_T : load_val[7:4];
      d_ones     = wrap ? MIN_O : borrow ? MAX_O : load_val[3:0];
      load_err_d = ~reset & load & ~load_ok;
   end
   // rejected-load flag, cleared by any cycle without a rejected load
   always_ff @(posedge clk) begin
      load_err_q <= load_err_d;
   end
   assign load_err    = load_err_q;
   assign unused_tens = t_co ^ t_bo;
   bcd_digit u_ones (
      .clk(clk), .reset(reset), .rst_val(MIN_O), .load(d_load), .load_val(d_ones),
      .up(up & ~at_max), .dn(dn & ~at_min), .top(4'd9), .q(q_ones), .co(o_co), .bo(o_bo)
   );
   bcd_digit u_tens (
      .clk(clk), .reset(reset), .rst_val(MIN_T), .load(d_load), .load_val(d_tens),
      .up(o_co), .dn(o_bo), .top(4'd9), .q(q_tens), .co(t_co), .bo(t_bo)
   );
endmodule

// File: tb/tb_bcd_field_cnt.sv
// tb_bcd_field_cnt: directed and randomized checks of bcd_field_cnt against an integer model
module tb_bcd_field_cnt;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   logic reset;
   logic i0, d0, l0, i1, d1, l1, i2, d2, l2, l3, l4;
   logic [7:0] lv0, lv1, lv2, lv3, lv4;
   logic [3:0] t0, o0, t1, o1, t2, o2, t3, o3, t4, o4;
   logic w0, b0, m0, e0, w1, b1, m1, e1, w2, b2, m2, e2, w3, b3, m3, e3, w4, b4, m4, e4;

   bcd_field_cnt u_def (.clk(clk), .reset(reset), .inc(i0), .dec(d0), .load(l0), .load_val(lv0),
      .q_tens(t0), .q_ones(o0), .wrap(w0), .borrow(b0), .at_max(m0), .load_err(e0));
   bcd_field_cnt #(.MAX_VAL(12), .MIN_VAL(1)) u_h12 (.clk(clk), .reset(reset), .inc(i1), .dec(d1),
      .load(l1), .load_val(lv1), .q_tens(t1), .q_ones(o1), .wrap(w1), .borrow(b1), .at_max(m1), .load_err(e1));
   bcd_field_cnt #(.MAX_VAL(59)) u_sec (.clk(clk), .reset(reset), .inc(i2), .dec(d2), .load(l2),
      .load_val(lv2), .q_tens(t2), .q_ones(o2), .wrap(w2), .borrow(b2), .at_max(m2), .load_err(e2));
   bcd_field_cnt #(.MAX_VAL(59)) u_min (.clk(clk), .reset(reset), .inc(w2), .dec(b2), .load(l3),
      .load_val(lv3), .q_tens(t3), .q_ones(o3), .wrap(w3), .borrow(b3), .at_max(m3), .load_err(e3));
   bcd_field_cnt #(.MAX_VAL(23)) u_hr (.clk(clk), .reset(reset), .inc(w3), .dec(b3), .load(l4),
      .load_val(lv4), .q_tens(t4), .q_ones(o4), .wrap(w4), .borrow(b4), .at_max(m4), .load_err(e4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      {i0, d0, l0, i1, d1, l1, i2, d2, l2, l3, l4} = '0;
      {lv0, lv1, lv2, lv3, lv4} = '0;
   endtask

   function automatic logic [7:0] enc(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic void mstep(input int mn, input int mx, input logic r, input logic l, input logic i,
                                 input logic d, input logic [7:0] lv, input int v,
                                 output int nv, output logic ne, output logic w, output logic b);
      int t, o;
      t = int'(lv[7:4]);
      o = int'(lv[3:0]);
      nv = v; ne = 1'b0; w = 1'b0; b = 1'b0;
      if (r) nv = mn;
      else if (l) begin
         if (t <= 9 && o <= 9 && t * 10 + o >= mn && t * 10 + o <= mx) nv = t * 10 + o;
         else ne = 1'b1;
      end else if (i && !d) begin
         w = (v == mx);
         nv = w ? mn : v + 1;
      end else if (d && !i) begin
         b = (v == mn);
         nv = b ? mx : v - 1;
      end
   endfunction

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if ({t0, o0} !== 8'h00) begin errors++; $display("FAIL reset_def got %h exp 00", {t0, o0}); end
      checks++; if ({m0, e0} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {m0, e0}); end
      checks++; if ({t1, o1} !== 8'h01) begin errors++; $display("FAIL reset_h12 got %h exp 01", {t1, o1}); end
      l0 = 1'b1; lv0 = 8'h23;
      tick();
      l0 = 1'b0; reset = 1'b1; i0 = 1'b1;
      #1;
      checks++; if (w0 !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", w0); end
      tick();
      checks++; if ({t0, o0} !== 8'h00) begin errors++; $display("FAIL reset_over_inc got %h exp 00", {t0, o0}); end
      reset = 1'b0; i0 = 1'b0;
   endtask

   task automatic test_count_up();
      idle();
      i0 = 1'b1;
      repeat (9) tick();
      checks++; if ({t0, o0} !== 8'h09) begin errors++; $display("FAIL up9 got %h exp 09", {t0, o0}); end
      checks++; if (w0 !== 1'b0) begin errors++; $display("FAIL up_nowrap got %b exp 0", w0); end
      tick();
      checks++; if ({t0, o0} !== 8'h10) begin errors++; $display("FAIL up10 got %h exp 10", {t0, o0}); end
      i0 = 1'b0; l0 = 1'b1; lv0 = 8'h23;
      tick();
      l0 = 1'b0;
      checks++; if (m0 !== 1'b1) begin errors++; $display("FAIL at_max got %b exp 1", m0); end
      i0 = 1'b1;
      #1;
      checks++; if (w0 !== 1'b1) begin errors++; $display("FAIL wrap23 got %b exp 1", w0); end
      tick();
      i0 = 1'b0;
      checks++; if ({t0, o0} !== 8'h00) begin errors++; $display("FAIL wrap_val got %h exp 00", {t0, o0}); end
   endtask

   task automatic test_h12();
      idle();
      l1 = 1'b1; lv1 = 8'h12;
      tick();
      l1 = 1'b0; i1 = 1'b1;
      #1;
      checks++; if (w1 !== 1'b1) begin errors++; $display("FAIL h12_wrap got %b exp 1", w1); end
      tick();
      checks++; if ({t1, o1} !== 8'h01) begin errors++; $display("FAIL h12_inc got %h exp 01", {t1, o1}); end
      i1 = 1'b0; d1 = 1'b1;
      #1;
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL h12_borrow got %b exp 1", b1); end
      tick();
      d1 = 1'b0;
      checks++; if ({t1, o1} !== 8'h12) begin errors++; $display("FAIL h12_dec got %h exp 12", {t1, o1}); end
   endtask

   task automatic test_max59();
      idle();
      l2 = 1'b1; lv2 = 8'h40;
      tick();
      l2 = 1'b0; d2 = 1'b1;
      tick();
      checks++; if ({t2, o2} !== 8'h39) begin errors++; $display("FAIL m59_dec got %h exp 39", {t2, o2}); end
      d2 = 1'b0; l2 = 1'b1; lv2 = 8'h00;
      tick();
      l2 = 1'b0; d2 = 1'b1;
      #1;
      checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL m59_borrow got %b exp 1", b2); end
      tick();
      d2 = 1'b0;
      checks++; if ({t2, o2} !== 8'h59) begin errors++; $display("FAIL m59_wrapdn got %h exp 59", {t2, o2}); end
   endtask

   task automatic test_load_err();
      logic [7:0] bad [3];
      bad = '{8'h25, 8'h1A, 8'hA0};
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      foreach (bad[k]) begin
         l0 = 1'b1; lv0 = bad[k];
         tick();
         checks++; if ({t0, o0, e0} !== 9'b0000_0000_1) begin errors++; $display("FAIL bad_load %h got %h err %b exp 00 err 1", bad[k], {t0, o0}, e0); end
      end
      l0 = 1'b0;
      tick();
      checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", e0); end
   endtask

   task automatic test_conflict();
      idle();
      l0 = 1'b1; lv0 = 8'h05;
      tick();
      l0 = 1'b0; i0 = 1'b1; d0 = 1'b1;
      #1;
      checks++; if ({w0, b0} !== 2'b00) begin errors++; $display("FAIL both_flags got %b exp 00", {w0, b0}); end
      tick();
      checks++; if ({t0, o0} !== 8'h05) begin errors++; $display("FAIL both_hold got %h exp 05", {t0, o0}); end
      i0 = 1'b0; d0 = 1'b0; l0 = 1'b1; lv0 = 8'h23;
      tick();
      lv0 = 8'h10; i0 = 1'b1;
      #1;
      checks++; if (w0 !== 1'b0) begin errors++; $display("FAIL load_inc_wrap got %b exp 0", w0); end
      tick();
      checks++; if ({t0, o0} !== 8'h10) begin errors++; $display("FAIL load_inc got %h exp 10", {t0, o0}); end
      i0 = 1'b0; reset = 1'b1; lv0 = 8'h15;
      tick();
      checks++; if ({t0, o0} !== 8'h00) begin errors++; $display("FAIL reset_load got %h exp 00", {t0, o0}); end
      reset = 1'b0; l0 = 1'b0;
   endtask

   task automatic test_chain();
      idle();
      l2 = 1'b1; lv2 = 8'h59; l3 = 1'b1; lv3 = 8'h59; l4 = 1'b1; lv4 = 8'h23;
      tick();
      l2 = 1'b0; l3 = 1'b0; l4 = 1'b0; i2 = 1'b1;
      #1;
      checks++; if ({w2, w3, w4} !== 3'b111) begin errors++; $display("FAIL chain_wrap got %b exp 111", {w2, w3, w4}); end
      tick();
      i2 = 1'b0;
      checks++; if ({t2, o2, t3, o3, t4, o4} !== 24'h0) begin errors++; $display("FAIL chain_val got %h exp 000000", {t2, o2, t3, o3, t4, o4}); end
   endtask

   task automatic test_random();
      int v [5], nv [5], mn [5], mx [5];
      logic [4:0] le, nle, ew, eb;
      logic [7:0] lv [5];
      logic [39:0] ev;
      mn = '{0, 1, 0, 0, 0};
      mx = '{23, 12, 59, 59, 23};
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      foreach (v[k]) v[k] = mn[k];
      le = '0;
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(31) == 0);
         foreach (lv[k]) lv[k] = $urandom_range(1) ? 8'($urandom_range(255)) : enc($urandom_range(99));
         {lv0, lv1, lv2, lv3, lv4} = {lv[0], lv[1], lv[2], lv[3], lv[4]};
         l0 = ($urandom_range(7) == 0); l1 = ($urandom_range(7) == 0); l2 = ($urandom_range(7) == 0);
         l3 = ($urandom_range(15) == 0); l4 = ($urandom_range(15) == 0);
         {i0, d0, i1, d1} = 4'($urandom_range(15));
         i2 = ($urandom_range(3) != 0); d2 = ($urandom_range(3) == 0);
         mstep(mn[0], mx[0], reset, l0, i0, d0, lv[0], v[0], nv[0], nle[0], ew[0], eb[0]);
         mstep(mn[1], mx[1], reset, l1, i1, d1, lv[1], v[1], nv[1], nle[1], ew[1], eb[1]);
         mstep(mn[2], mx[2], reset, l2, i2, d2, lv[2], v[2], nv[2], nle[2], ew[2], eb[2]);
         mstep(mn[3], mx[3], reset, l3, ew[2], eb[2], lv[3], v[3], nv[3], nle[3], ew[3], eb[3]);
         mstep(mn[4], mx[4], reset, l4, ew[3], eb[3], lv[4], v[4], nv[4], nle[4], ew[4], eb[4]);
         #1;
         checks++; if ({w0, w1, w2, w3, w4, b0, b1, b2, b3, b4} !== {ew[0], ew[1], ew[2], ew[3], ew[4], eb[0], eb[1], eb[2], eb[3], eb[4]}) begin
            errors++; $display("FAIL rnd_carry cyc %0d got %b exp %b", n, {w0, w1, w2, w3, w4, b0, b1, b2, b3, b4},
               {ew[0], ew[1], ew[2], ew[3], ew[4], eb[0], eb[1], eb[2], eb[3], eb[4]});
         end
         tick();
         v = nv;
         le = nle;
         ev = {enc(v[0]), enc(v[1]), enc(v[2]), enc(v[3]), enc(v[4])};
         checks++; if ({t0, o0, t1, o1, t2, o2, t3, o3, t4, o4} !== ev) begin
            errors++; $display("FAIL rnd_val cyc %0d got %h exp %h", n, {t0, o0, t1, o1, t2, o2, t3, o3, t4, o4}, ev);
         end
         checks++; if ({e0, e1, e2, e3, e4} !== {le[0], le[1], le[2], le[3], le[4]}) begin
            errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", n, {e0, e1, e2, e3, e4}, {le[0], le[1], le[2], le[3], le[4]});
         end
         checks++; if ({m0, m1, m2, m3, m4} !== {v[0] == mx[0], v[1] == mx[1], v[2] == mx[2], v[3] == mx[3], v[4] == mx[4]}) begin
            errors++; $display("FAIL rnd_atmax cyc %0d got %b", n, {m0, m1, m2, m3, m4});
         end
      end
      reset = 1'b0;
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      test_reset();
      test_count_up();
      test_h12();
      test_max59();
      test_load_err();
      test_conflict();
      test_chain();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_field_cnt.md
# bcd_field_cnt

Parametrised two-digit BCD time-field counter. It generalises the single-digit hour-tens register into a complete field (hours, minutes or seconds) with configurable range, increment and decrement, validated parallel load, and carry/borrow outputs. Instances chain through `wrap`/`borrow` into `inc`/`dec` of the next field (seconds→minutes→hours) to form the clock and alarm time registers.

## Interface
Parameters:
- `MAX_VAL`, default 23: highest field value (binary); legal range 1..99.
- `MIN_VAL`, default 0: lowest field value; must be 0 or 1 (1 for 12-hour mode); `MIN_VAL < MAX_VAL`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `inc`  in  1  count up one step this cycle (carry-in).
- `dec`  in  1  count down one step this cycle (borrow-in).
- `load`  in  1  load `load_val` if valid.
- `load_val`  in  8  `[7:4]` tens BCD, `[3:0]` ones BCD.
- `q_tens`  out  4  tens digit, BCD.
- `q_ones`  out  4  ones digit, BCD.
- `wrap`  out  1  combinational carry-out: `inc` accepted while value == MAX_VAL.
- `borrow`  out  1  combinational borrow-out: `dec` accepted while value == MIN_VAL.
- `at_max`  out  1  combinational: value == MAX_VAL.
- `load_err`  out  1  registered: previous cycle's load was rejected.

## Operation
- Value V = 10·q_tens + q_ones, always in [MIN_VAL, MAX_VAL]; digits always valid BCD (0–9).
- Per-edge priority: `reset` > `load` > (`inc` xor `dec`).
- `reset`: V ← MIN_VAL, `load_err` ← 0.
- `load`: valid iff both nibbles ≤ 9 and MIN_VAL ≤ value ≤ MAX_VAL. Valid: V ← load_val, `load_err` ← 0. Invalid: V held, `load_err` ← 1.
- `load_err` is cleared by any cycle without `load` and by reset; it is set only by a rejected load.
- `inc` only: V = MAX_VAL → MIN_VAL (`wrap`=1); else V+1 (ones 9 → 0 with tens+1).
- `dec` only: V = MIN_VAL → MAX_VAL (`borrow`=1); else V−1 (ones 0 → 9 with tens−1).
- `inc` and `dec` together: hold; `wrap` = `borrow` = 0.
- `wrap` and `borrow` are forced to 0 during `reset` or `load`, so a suppressed step never propagates a carry to the next field.
- Arithmetic is done digit-wise in BCD; no binary-to-BCD conversion on the count path.

## Timing
- Reset values: q_tens/q_ones = BCD of MIN_VAL (00 or 01); `load_err`=0; `at_max`=0; `wrap`/`borrow`=0 while reset is asserted.
- Latency: outputs update one clock after the qualifying input edge.
- `wrap`/`borrow` are same-cycle combinational, so a chained next field steps on the same edge (no ripple delay across fields).
- Asserting reset mid-chain returns this field to MIN_VAL regardless of `inc`/`dec`/`load` in the same cycle.

## Structure
- Shared package `time_pkg`: `typedef logic [3:0] bcd_t`; `function bcd_valid(bcd_t)`; `function bcd2_to_int(bcd_t tens, bcd_t ones)`; constants `HR24_MAX=23`, `HR12_MIN=1`, `HR12_MAX=12`, `MS_MAX=59`.
- Sub-module `bcd_digit`: one BCD digit with up/down step, terminal-value inputs, load, and carry/borrow-out. Two instances make up the field; field-level terminal detection on MIN_VAL/MAX_VAL lives in `bcd_field_cnt`.

## Test plan
- Defaults: reset → 00; 9 `inc` pulses → 09; 1 more → 10, `wrap`=0; load 0x23 → `at_max`=1; `inc` → 00 with `wrap`=1 in that cycle.
- MIN_VAL=1, MAX_VAL=12: reset → 01; load 0x12, `inc` → 01 with `wrap`=1; `dec` at 01 → 12 with `borrow`=1.
- MAX_VAL=59: load 0x40, `dec` → 39; load 0x00, `dec` → 59 with `borrow`=1.
- Defaults, rejected loads: loads of 0x25, 0x1A and 0xA0 each leave V unchanged with `load_err`=1 next cycle; a following idle cycle → `load_err`=0.
- Defaults, conflicts: `inc`+`dec` at 05 → 05 with `wrap`=`borrow`=0; `load` 0x10 + `inc` at 23 → 10 with `wrap`=0; `reset` + `load` 0x15 → 00.
- Chained fields: seconds(59)→minutes(59)→hours(23) all at max, one `inc` on the seconds field → all three become 00 on the same edge.
